// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the multi-slot alarm unit.
//   hhmm_t        : packed BCD hour/minute pair {hh, mm}
//   alarm_state_t : alarm sequencer states
//   bcd_inc_hour  : 00..23 increment with wrap
//   bcd_inc_min   : 00..59 increment with wrap, no carry out
//   bcd_add_min   : add n minutes (n <= 59) with hour carry and day wrap
package alarm_pkg;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
    } hhmm_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRing   = 2'd1,
        StSnooze = 2'd2
    } alarm_state_t;

    function automatic logic [7:0] bcd_inc_hour(input logic [7:0] hh);
        if (hh == 8'h23) begin
            return 8'h00;
        end else if (hh[3:0] == 4'd9) begin
            return {hh[7:4] + 4'd1, 4'd0};
        end else begin
            return {hh[7:4], hh[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcd_inc_min(input logic [7:0] mm);
        if (mm == 8'h59) begin
            return 8'h00;
        end else if (mm[3:0] == 4'd9) begin
            return {mm[7:4] + 4'd1, 4'd0};
        end else begin
            return {mm[7:4], mm[3:0] + 4'd1};
        end
    endfunction

    // n is at most 59, so at most one minute carry and one day wrap can occur.
    function automatic hhmm_t bcd_add_min(input hhmm_t t, input int unsigned n);
        logic [7:0] m;
        logic [7:0] h;
        hhmm_t      r;
        m = {4'd0, t.mm[7:4]} * 8'd10 + {4'd0, t.mm[3:0]} + 8'(n);
        h = {4'd0, t.hh[7:4]} * 8'd10 + {4'd0, t.hh[3:0]};
        if (m >= 8'd60) begin
            m = m - 8'd60;
            h = h + 8'd1;
        end
        if (h >= 8'd24) begin
            h = h - 8'd24;
        end
        r.mm = {4'(m / 8'd10), 4'(m % 8'd10)};
        r.hh = {4'(h / 8'd10), 4'(h % 8'd10)};
        return r;
    endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Buzzer tone generator: a square wave at BEEP_HZ, gated on/off in phases of
// CADENCE_MS. All counters are held at zero while disabled, so every enable
// starts with the tone high in the on phase.
//   sys_clk, rst_n : clock, async active-low reset
//   enable         : ring active
//   mute           : force output low without stopping the counters
//   beep_out       : buzzer drive
module alarm_tone_gen #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BEEP_HZ    = 2000,
    parameter int unsigned CADENCE_MS = 500
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic enable,
    input  logic mute,
    output logic beep_out
);

    localparam longint unsigned HALF_CYC = 64'(CLK_HZ) / (64'd2 * 64'(BEEP_HZ));
    localparam longint unsigned CAD_CYC  = 64'(CLK_HZ) * 64'(CADENCE_MS) / 64'd1000;
    localparam int unsigned DIV_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int unsigned CAD_W = (CAD_CYC > 1) ? $clog2(CAD_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_CYC - 1);
    localparam logic [CAD_W-1:0] CAD_LAST = CAD_W'(CAD_CYC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CAD_W-1:0] cad_q, cad_d;
    logic             tone_low_q, tone_low_d;
    logic             cad_off_q, cad_off_d;

    always_comb begin
        div_d      = div_q;
        cad_d      = cad_q;
        tone_low_d = tone_low_q;
        cad_off_d  = cad_off_q;
        if (!enable) begin
            div_d      = '0;
            cad_d      = '0;
            tone_low_d = 1'b0;
            cad_off_d  = 1'b0;
        end else begin
            if (div_q == DIV_LAST) begin
                div_d      = '0;
                tone_low_d = ~tone_low_q;
            end else begin
                div_d = div_q + 1'b1;
            end
            if (cad_q == CAD_LAST) begin
                cad_d     = '0;
                cad_off_d = ~cad_off_q;
            end else begin
                cad_d = cad_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            cad_q      <= '0;
            tone_low_q <= 1'b0;
            cad_off_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            cad_q      <= cad_d;
            tone_low_q <= tone_low_d;
            cad_off_q  <= cad_off_d;
        end
    end

    assign beep_out = enable & ~mute & ~tone_low_q & ~cad_off_q;

endmodule

// File: rtl/alarm_multi.sv
// Multi-slot alarm unit: N_ALARMS settable hh:mm alarms compared against the
// running BCD time, with ring / snooze / auto-timeout sequencing and a
// cadenced buzzer.
//   sys_clk, rst_n      : clock, async active-low reset
//   *_pre               : one-cycle key pulses (hour, minute, slot, confirm/cancel, snooze)
//   mode_alarm          : set keys live
//   mode_timer          : mute buzzer
//   cnt_24              : current time, [23:0] BCD hhmmss
//   disp_alarm          : {8'h00, hh, mm, 4'h0, sel} of the selected slot
//   alarm_en            : per-slot enables, alarm_indicator their OR
//   ringing/active_slot : ring status and the slot responsible
//   beep_out            : buzzer drive
module alarm_multi
    import alarm_pkg::*;
#(
    parameter int unsigned N_ALARMS   = 4,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BEEP_HZ    = 2000,
    parameter int unsigned CADENCE_MS = 500,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                hour_set_pre,
    input  logic                min_set_pre,
    input  logic                slot_sel_pre,
    input  logic                confirm_cancel_pre,
    input  logic                snooze_pre,
    input  logic                mode_alarm,
    input  logic                mode_timer,
    input  logic [31:0]         cnt_24,
    output logic [31:0]         disp_alarm,
    output logic [N_ALARMS-1:0] alarm_en,
    output logic                alarm_indicator,
    output logic                ringing,
    output logic [3:0]          active_slot,
    output logic                beep_out
);

    localparam int unsigned SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam longint unsigned RING_CYC = 64'(RING_SEC) * 64'(CLK_HZ);
    localparam int unsigned RING_W = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_CYC - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_ALARMS - 1);

    hhmm_t               slot_q [N_ALARMS];
    logic [N_ALARMS-1:0] en_q;
    logic [SEL_W-1:0]    sel_q;
    logic [23:0]         cnt_q;

    alarm_state_t        state_q, state_d;
    logic [SEL_W-1:0]    active_q, active_d;
    hhmm_t               snz_q, snz_d;
    logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;

    hhmm_t               now_hm;
    logic                tick;
    logic [N_ALARMS-1:0] hit;
    logic                hit_any, oth_any;
    logic [SEL_W-1:0]    hit_idx, oth_idx;
    logic                unused_cnt_hi;

    assign unused_cnt_hi = ^cnt_24[31:24];
    assign now_hm        = hhmm_t'(cnt_24[23:8]);

    // Fires once on the first cycle a new hh:mm:00 value is presented.
    assign tick = (cnt_24[23:0] != cnt_q) && (cnt_24[7:0] == 8'h00);

    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            hit[i] = tick && en_q[i] && (slot_q[i] == now_hm);
        end
    end

    // Lowest-index hit overall, and lowest hit excluding the snoozed slot.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        oth_any = 1'b0;
        oth_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
                if (SEL_W'(i) != active_q) begin
                    oth_any = 1'b1;
                    oth_idx = SEL_W'(i);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                slot_q[i] <= '0;
            end
            en_q  <= '0;
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_24[23:0];
            if (mode_alarm) begin
                if (hour_set_pre) begin
                    slot_q[sel_q].hh <= bcd_inc_hour(slot_q[sel_q].hh);
                end
                if (min_set_pre) begin
                    slot_q[sel_q].mm <= bcd_inc_min(slot_q[sel_q].mm);
                end
                if (slot_sel_pre) begin
                    sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                end
                // In RING/SNOOZE the same key cancels instead of toggling.
                if (confirm_cancel_pre && (state_q == StIdle)) begin
                    en_q[sel_q] <= ~en_q[sel_q];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        snz_d      = snz_q;
        ring_cnt_d = ring_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (hit_any) begin
                    state_d    = StRing;
                    active_d   = hit_idx;
                    ring_cnt_d = '0;
                end
            end
            StRing: begin
                if (confirm_cancel_pre) begin
                    state_d = StIdle;
                end else if (snooze_pre) begin
                    state_d = StSnooze;
                    snz_d   = bcd_add_min(now_hm, SNOOZE_MIN);
                end else if (ring_cnt_q == RING_LAST) begin
                    state_d = StIdle;
                end else begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                end
            end
            StSnooze: begin
                if (confirm_cancel_pre || !en_q[active_q]) begin
                    state_d = StIdle;
                end else if (tick && (now_hm == snz_q)) begin
                    state_d    = StRing;
                    ring_cnt_d = '0;
                end else if (oth_any) begin
                    state_d    = StRing;
                    active_d   = oth_idx;
                    ring_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            active_q   <= '0;
            snz_q      <= '0;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            snz_q      <= snz_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    alarm_tone_gen #(
        .CLK_HZ     (CLK_HZ),
        .BEEP_HZ    (BEEP_HZ),
        .CADENCE_MS (CADENCE_MS)
    ) u_tone (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .enable   (ringing),
        .mute     (mode_timer),
        .beep_out (beep_out)
    );

    assign disp_alarm      = {8'h00, slot_q[sel_q].hh, slot_q[sel_q].mm, 4'h0, 4'(sel_q)};
    assign alarm_en        = en_q;
    assign alarm_indicator = |en_q;
    assign ringing         = (state_q == StRing);
    assign active_slot     = 4'(active_q);

endmodule

// File: tb/tb_alarm_multi.sv
// Randomised self-checking bench for alarm_multi with a minute-of-day
// reference model.
module tb_alarm_multi;

    localparam int N        = 4;
    localparam int HALF     = 5;     // 1000 / (2*100)
    localparam int CAD      = 20;    // 1000 * 20 / 1000
    localparam int RING_CYC = 2000;  // 2 s * 1000 Hz
    localparam int SNZ      = 5;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          hour_set_pre = 1'b0, min_set_pre = 1'b0, slot_sel_pre = 1'b0;
    logic          confirm_cancel_pre = 1'b0, snooze_pre = 1'b0;
    logic          mode_alarm = 1'b0, mode_timer = 1'b0;
    logic [31:0]   cnt_24 = '0;
    logic [31:0]   disp_alarm;
    logic [N-1:0]  alarm_en;
    logic          alarm_indicator, ringing, beep_out;
    logic [3:0]    active_slot;

    int checks = 0;
    int errors = 0;

    // Reference model: slot times as minute-of-day integers.
    int          m_min [N];
    bit          m_en  [N];
    int          m_sel, m_active, m_snz_min, m_age;
    bit          m_ring, m_snz;
    logic [23:0] m_prev;

    alarm_multi #(
        .N_ALARMS   (N),
        .CLK_HZ     (1000),
        .BEEP_HZ    (100),
        .CADENCE_MS (20),
        .RING_SEC   (2),
        .SNOOZE_MIN (SNZ)
    ) dut (
        .sys_clk            (sys_clk),
        .rst_n              (rst_n),
        .hour_set_pre       (hour_set_pre),
        .min_set_pre        (min_set_pre),
        .slot_sel_pre       (slot_sel_pre),
        .confirm_cancel_pre (confirm_cancel_pre),
        .snooze_pre         (snooze_pre),
        .mode_alarm         (mode_alarm),
        .mode_timer         (mode_timer),
        .cnt_24             (cnt_24),
        .disp_alarm         (disp_alarm),
        .alarm_en           (alarm_en),
        .alarm_indicator    (alarm_indicator),
        .ringing            (ringing),
        .active_slot        (active_slot),
        .beep_out           (beep_out)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int unbcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [31:0] mk_time(input int h, input int m, input int s);
        return {8'h00, bcd(h), bcd(m), bcd(s)};
    endfunction

    function automatic logic [31:0] exp_disp();
        return {8'h00, bcd(m_min[m_sel] / 60), bcd(m_min[m_sel] % 60), 4'h0, 4'(m_sel)};
    endfunction

    function automatic logic [N-1:0] exp_en();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_en[i];
        return v;
    endfunction

    function automatic bit exp_beep();
        return m_ring && !mode_timer && ((m_age / HALF) % 2 == 0) && ((m_age / CAD) % 2 == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_min[i] = 0;
            m_en[i]  = 1'b0;
        end
        m_sel = 0; m_active = 0; m_snz_min = 0; m_age = 0;
        m_ring = 1'b0; m_snz = 1'b0; m_prev = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_update();
        int cur, lo, lo_oth, s;
        bit tick, was_idle;
        cur  = unbcd(cnt_24[23:16]) * 60 + unbcd(cnt_24[15:8]);
        tick = (cnt_24[23:0] != m_prev) && (cnt_24[7:0] == 8'h00);
        lo = -1;
        lo_oth = -1;
        for (int i = 0; i < N; i++) begin
            if (tick && m_en[i] && m_min[i] == cur) begin
                if (lo < 0) lo = i;
                if (i != m_active && lo_oth < 0) lo_oth = i;
            end
        end
        was_idle = !m_ring && !m_snz;
        if (m_ring) begin
            if (confirm_cancel_pre) m_ring = 1'b0;
            else if (snooze_pre) begin
                m_ring = 1'b0; m_snz = 1'b1; m_snz_min = (cur + SNZ) % 1440;
            end else if (m_age == RING_CYC - 1) m_ring = 1'b0;
            else m_age++;
        end else if (m_snz) begin
            if (confirm_cancel_pre || !m_en[m_active]) m_snz = 1'b0;
            else if (tick && cur == m_snz_min) begin
                m_snz = 1'b0; m_ring = 1'b1; m_age = 0;
            end else if (lo_oth >= 0) begin
                m_snz = 1'b0; m_ring = 1'b1; m_age = 0; m_active = lo_oth;
            end
        end else if (lo >= 0) begin
            m_ring = 1'b1; m_active = lo; m_age = 0;
        end
        s = m_sel;
        if (mode_alarm) begin
            if (hour_set_pre) m_min[s] = ((m_min[s] / 60 + 1) % 24) * 60 + m_min[s] % 60;
            if (min_set_pre) m_min[s] = (m_min[s] / 60) * 60 + (m_min[s] % 60 + 1) % 60;
            if (slot_sel_pre) m_sel = (m_sel + 1) % N;
            if (confirm_cancel_pre && was_idle) m_en[s] = !m_en[s];
        end
        m_prev = cnt_24[23:0];
    endtask

    task automatic step();
        model_update();
        @(posedge sys_clk);
        #1;
    endtask

    // k: 0 hour, 1 minute, 2 slot, 3 confirm/cancel, 4 snooze
    task automatic press(input int k);
        case (k)
            0: hour_set_pre = 1'b1;
            1: min_set_pre = 1'b1;
            2: slot_sel_pre = 1'b1;
            3: confirm_cancel_pre = 1'b1;
            default: snooze_pre = 1'b1;
        endcase
        step();
        {hour_set_pre, min_set_pre, slot_sel_pre, confirm_cancel_pre, snooze_pre} = '0;
    endtask

    task automatic set_slot(input int idx, input int h, input int m, input bit en);
        int nh, nm;
        mode_alarm = 1'b1;
        while (m_sel != idx) press(2);
        nh = (h - m_min[idx] / 60 + 24) % 24;
        nm = (m - m_min[idx] % 60 + 60) % 60;
        repeat (nh) press(0);
        repeat (nm) press(1);
        if (m_en[idx] != en) press(3);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cnt_24 = mk_time(h, m, s);
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #8;
        checks++;
        if ({disp_alarm, alarm_en, alarm_indicator, ringing, active_slot, beep_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got disp=%h en=%b ind=%b ring=%b act=%h beep=%b, want all 0",
                     disp_alarm, alarm_en, alarm_indicator, ringing, active_slot, beep_out);
        end
        model_reset();
        #10 rst_n = 1'b1;
        step();
        checks++;
        if (ringing !== 1'b0 || disp_alarm !== 32'h0 || alarm_en !== '0) begin
            errors++;
            $display("FAIL reset_release: got ring=%b disp=%h en=%b, want 0", ringing, disp_alarm,
                     alarm_en);
        end
    endtask

    task automatic test_keys();
        logic [31:0] pre;
        logic [N-1:0] pre_en;
        mode_alarm = 1'b1;
        for (int k = 1; k <= N; k++) begin
            press(2);
            checks++;
            if (disp_alarm[3:0] !== 4'(k % N)) begin
                errors++;
                $display("FAIL sel_wrap: got %h want %h", disp_alarm[3:0], 4'(k % N));
            end
        end
        repeat (N - 1) press(2);
        for (int k = 1; k <= 24; k++) begin
            press(0);
            checks++;
            if (disp_alarm[23:16] !== bcd(k % 24)) begin
                errors++;
                $display("FAIL hour_inc: got %h want %h", disp_alarm[23:16], bcd(k % 24));
            end
        end
        repeat (23) press(0);
        for (int k = 1; k <= 60; k++) begin
            press(1);
            checks++;
            if (disp_alarm[15:8] !== bcd(k % 60) || disp_alarm[23:16] !== 8'h23) begin
                errors++;
                $display("FAIL min_inc: got hh=%h mm=%h want hh=23 mm=%h", disp_alarm[23:16],
                         disp_alarm[15:8], bcd(k % 60));
            end
        end
        for (int k = 0; k < 12; k++) begin
            press(int'($urandom_range(0, 2)));
            checks++;
            if (disp_alarm !== exp_disp()) begin
                errors++;
                $display("FAIL rand_key: got %h want %h", disp_alarm, exp_disp());
            end
        end
        mode_alarm = 1'b0;
        pre = exp_disp();
        pre_en = exp_en();
        for (int k = 0; k < 4; k++) begin
            press(k);
            checks++;
            if (disp_alarm !== pre || alarm_en !== pre_en) begin
                errors++;
                $display("FAIL keys_ignored: got disp=%h en=%b want disp=%h en=%b", disp_alarm,
                         alarm_en, pre, pre_en);
            end
        end
    endtask

    task automatic test_ring_basic();
        bit eb;
        set_slot(1, 7, 30, 1'b1);
        mode_alarm = 1'b0;
        checks++;
        if (alarm_en[1] !== 1'b1 || alarm_indicator !== 1'b1 || disp_alarm[23:8] !== 16'h0730) begin
            errors++;
            $display("FAIL slot1_set: got en=%b ind=%b hhmm=%h want en[1]=1 ind=1 hhmm=0730",
                     alarm_en, alarm_indicator, disp_alarm[23:8]);
        end
        set_time(7, 29, 59);
        set_time(7, 30, 0);
        checks++;
        if (ringing !== 1'b1 || active_slot !== 4'd1 || beep_out !== 1'b1) begin
            errors++;
            $display("FAIL ring_entry: got ring=%b act=%h beep=%b want 1/1/1", ringing,
                     active_slot, beep_out);
        end
        for (int k = 1; k < RING_CYC; k++) begin
            step();
            eb = ((k / HALF) % 2 == 0) && ((k / CAD) % 2 == 0);
            checks++;
            if (ringing !== 1'b1 || beep_out !== eb) begin
                errors++;
                $display("FAIL ring_cadence: cycle %0d got ring=%b beep=%b want ring=1 beep=%b",
                         k, ringing, beep_out, eb);
            end
        end
        step();
        checks++;
        if (ringing !== 1'b0 || beep_out !== 1'b0 || alarm_en[1] !== 1'b1) begin
            errors++;
            $display("FAIL ring_timeout: got ring=%b beep=%b en1=%b want 0/0/1", ringing,
                     beep_out, alarm_en[1]);
        end
        repeat (5) step();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL held_time_retrigger: got ring=%b want 0", ringing);
        end
    endtask

    task automatic test_snooze();
        set_slot(2, 23, 58, 1'b1);
        mode_alarm = 1'b0;
        set_time(23, 58, 0);
        checks++;
        if (ringing !== 1'b1 || active_slot !== 4'd2) begin
            errors++;
            $display("FAIL snz_ring: got ring=%b act=%h want 1/2", ringing, active_slot);
        end
        set_time(23, 58, 30);
        press(4);
        checks++;
        if (ringing !== 1'b0 || beep_out !== 1'b0) begin
            errors++;
            $display("FAIL snz_enter: got ring=%b beep=%b want 0/0", ringing, beep_out);
        end
        set_time(23, 59, 0);
        set_time(0, 2, 0);
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL snz_early: got ring=%b want 0", ringing);
        end
        set_time(0, 3, 0);
        checks++;
        if (ringing !== 1'b1 || active_slot !== 4'd2) begin
            errors++;
            $display("FAIL snz_wake: got ring=%b act=%h want 1/2", ringing, active_slot);
        end
        press(4);
        set_time(7, 30, 0);
        checks++;
        if (ringing !== 1'b1 || active_slot !== 4'd1) begin
            errors++;
            $display("FAIL snz_other_hit: got ring=%b act=%h want 1/1", ringing, active_slot);
        end
        press(3);
        checks++;
        if (ringing !== 1'b0 || alarm_en !== 4'b0110) begin
            errors++;
            $display("FAIL snz_cancel: got ring=%b en=%b want 0/0110", ringing, alarm_en);
        end
    endtask

    task automatic test_same_minute();
        set_slot(0, 12, 0, 1'b1);
        set_slot(2, 12, 0, 1'b1);
        mode_alarm = 1'b0;
        set_time(12, 0, 0);
        checks++;
        if (ringing !== 1'b1 || active_slot !== 4'd0) begin
            errors++;
            $display("FAIL lowest_slot: got ring=%b act=%h want 1/0", ringing, active_slot);
        end
        press(3);
        repeat (5) step();
        checks++;
        if (ringing !== 1'b0) begin
            errors++;
            $display("FAIL same_minute_retrigger: got ring=%b want 0", ringing);
        end
    endtask

    task automatic test_mute();
        set_time(12, 0, 1);
        set_time(12, 0, 0);
        checks++;
        if (ringing !== 1'b1 || active_slot !== 4'd0) begin
            errors++;
            $display("FAIL mute_ring: got ring=%b act=%h want 1/0", ringing, active_slot);
        end
        mode_timer = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (beep_out !== 1'b0 || ringing !== 1'b1) begin
                errors++;
                $display("FAIL muted: got beep=%b ring=%b want 0/1", beep_out, ringing);
            end
        end
        mode_timer = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (beep_out !== exp_beep()) begin
                errors++;
                $display("FAIL unmuted_beep: got %b want %b", beep_out, exp_beep());
            end
        end
        press(3);
        checks++;
        if (ringing !== 1'b0 || beep_out !== 1'b0) begin
            errors++;
            $display("FAIL mute_cancel: got ring=%b beep=%b want 0/0", ringing, beep_out);
        end
    endtask

    task automatic test_random();
        int s;
        for (int k = 0; k < 3000; k++) begin
            mode_alarm = ($urandom_range(0, 3) != 0);
            mode_timer = ($urandom_range(0, 4) == 0);
            hour_set_pre = ($urandom_range(0, 9) == 0);
            min_set_pre = ($urandom_range(0, 9) == 0);
            slot_sel_pre = ($urandom_range(0, 9) == 0);
            confirm_cancel_pre = ($urandom_range(0, 39) == 0);
            snooze_pre = ($urandom_range(0, 19) == 0);
            s = int'($urandom_range(0, N - 1));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0, 1: cnt_24 = mk_time(m_min[s] / 60, m_min[s] % 60, 0);
                    2: cnt_24 = mk_time(m_snz_min / 60, m_snz_min % 60, 0);
                    3: cnt_24 = mk_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), 0);
                    default: cnt_24 = mk_time(int'($urandom_range(0, 23)),
                                              int'($urandom_range(0, 59)),
                                              int'($urandom_range(1, 59)));
                endcase
            end
            step();
            {hour_set_pre, min_set_pre, slot_sel_pre, confirm_cancel_pre, snooze_pre} = '0;
            checks++;
            if (disp_alarm !== exp_disp() || alarm_en !== exp_en() ||
                alarm_indicator !== (exp_en() != '0) || ringing !== m_ring ||
                beep_out !== exp_beep() || (m_ring && active_slot !== 4'(m_active))) begin
                errors++;
                $display("FAIL random_cycle %0d: got disp=%h en=%b ring=%b act=%h beep=%b want disp=%h en=%b ring=%b act=%0d beep=%b",
                         k, disp_alarm, alarm_en, ringing, active_slot, beep_out, exp_disp(),
                         exp_en(), m_ring, m_active, exp_beep());
            end
        end
        mode_timer = 1'b0;
        mode_alarm = 1'b0;
    endtask

    task automatic test_async_reset();
        if (m_ring || m_snz) press(3);
        set_slot(0, 9, 15, 1'b1);
        mode_alarm = 1'b0;
        set_time(9, 15, 0);
        repeat (2) step();
        checks++;
        if (ringing !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ring: got ring=%b want 1", ringing);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({disp_alarm, alarm_en, alarm_indicator, ringing, active_slot, beep_out} !== '0) begin
            errors++;
            $display("FAIL async_reset: got disp=%h en=%b ind=%b ring=%b act=%h beep=%b, want all 0",
                     disp_alarm, alarm_en, alarm_indicator, ringing, active_slot, beep_out);
        end
        model_reset();
        #3 rst_n = 1'b1;
        step();
        checks++;
        if (ringing !== 1'b0 || alarm_en !== '0) begin
            errors++;
            $display("FAIL post_reset: got ring=%b en=%b want 0/0", ringing, alarm_en);
        end
    endtask

    initial begin
        test_reset();
        test_keys();
        test_ring_basic();
        test_snooze();
        test_same_minute();
        test_mute();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
